// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the streaming dot-product controller.
package dot_product_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SAT_MAX_WIDTH = 256;

   // Smallest accumulator that holds one full chunk sum with sign headroom.
   function automatic int acc_min_width(input int ew, input int n);
      return 2 * ew + $clog2(n) + 1;
   endfunction

   function automatic logic [SAT_MAX_WIDTH-1:0] sat_max(input int w);
      logic [SAT_MAX_WIDTH-1:0] one;
      one = {{(SAT_MAX_WIDTH-1){1'b0}}, 1'b1};
      return (one << (w - 1)) - one;
   endfunction

   function automatic logic [SAT_MAX_WIDTH-1:0] sat_min(input int w);
      logic [SAT_MAX_WIDTH-1:0] one;
      one = {{(SAT_MAX_WIDTH-1){1'b0}}, 1'b1};
      return one << (w - 1);
   endfunction

endpackage

// File: rtl/dot_lane_adder_tree.sv
// Combinational pairwise adder tree: NO_OF_UNITS signed products summed at ACC_WIDTH.
module dot_lane_adder_tree #(
   parameter int NO_OF_UNITS   = 8,
   parameter int PRODUCT_WIDTH = 64,
   parameter int ACC_WIDTH     = 80
) (
   input  logic [NO_OF_UNITS*PRODUCT_WIDTH-1:0] products,
   output logic signed [ACC_WIDTH-1:0]          sum
);

   localparam int LEVELS = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 0;
   localparam int LEAVES = 1 << LEVELS;

   // Heap layout: node 0 is the root, leaves start at LEAVES-1; unused leaves stay zero.
   logic signed [ACC_WIDTH-1:0] node [2*LEAVES-1];

   always_comb begin
      node = '{default: '0};
      for (int i = 0; i < NO_OF_UNITS; i++) begin
         node[LEAVES-1+i] = ACC_WIDTH'($signed(products[i*PRODUCT_WIDTH +: PRODUCT_WIDTH]));
      end
      for (int j = LEAVES - 2; j >= 0; j--) begin
         node[j] = node[2*j+1] + node[2*j+2];
      end
      sum = node[0];
   end

endmodule

// File: rtl/dot_product_stream_ctrl.sv
// Streaming dot-product controller: chunked valid/ready input, tail masking, held result.
// Optional DOT_PRODUCT_SATURATE_EN: saturating accumulator with sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting chunks until the last beat is taken
// DRAIN | product/accumulate pipeline emptying
// DONE  | result valid, finish held until result_ready
module dot_product_stream_ctrl
   import dot_product_pkg::*;
#(
   parameter int ELEMENT_WIDTH = 32,
   parameter int NO_OF_UNITS   = 8,
   parameter int ACC_WIDTH     = 80,
   parameter int TOTAL_WIDTH   = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [TOTAL_WIDTH-1:0]               total,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] vector1,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] vector2,
   output logic [ACC_WIDTH-1:0]                 result,
   output logic                                 finish,
   input  logic                                 result_ready,
   output logic                                 busy,
   output logic                                 overflow
);

   localparam int PW     = 2 * ELEMENT_WIDTH;
   localparam int LANE_W = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;

   if (NO_OF_UNITS < 1) begin : g_units_err
      $error("NO_OF_UNITS must be at least 1");
   end
   if (ACC_WIDTH < acc_min_width(ELEMENT_WIDTH, NO_OF_UNITS)) begin : g_acc_width_err
      $error("ACC_WIDTH too small for ELEMENT_WIDTH and NO_OF_UNITS");
   end

   state_t                          state_q, state_d;
   logic                            start_take;
   logic                            accept;
   logic                            last_beat;
   logic [TOTAL_WIDTH-1:0]          start_chunks;
   logic [LANE_W-1:0]               start_tail;
   logic [TOTAL_WIDTH-1:0]          beats_left_q;
   logic [LANE_W-1:0]               tail_q;
   logic                            valid1_q;
   logic [NO_OF_UNITS*PW-1:0]       prod_d, prod_q;
   logic signed [ACC_WIDTH-1:0]     tree_sum;
   logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;

   assign in_ready  = (state_q == LOAD);
   assign finish    = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = acc_q;
   assign accept    = in_valid && in_ready;
   assign last_beat = accept && (beats_left_q == TOTAL_WIDTH'(1));

   always_comb begin
      start_tail   = LANE_W'(total % TOTAL_WIDTH'(NO_OF_UNITS));
      start_chunks = total / TOTAL_WIDTH'(NO_OF_UNITS);
      if (start_tail != '0) begin
         start_chunks = start_chunks + TOTAL_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start_take = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_take = 1'b1;
               state_d    = (total == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (last_beat) state_d = DRAIN;
         end
         DRAIN: begin
            if (!valid1_q) state_d = DONE;
         end
         DONE: begin
            if (result_ready) begin
               if (start) begin
                  start_take = 1'b1;
                  state_d    = (total == '0) ? DONE : LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Remaining-chunk down-counter; terminal count 1 marks the last beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beats_left_q <= '0;
         tail_q       <= '0;
      end else if (start_take) begin
         beats_left_q <= start_chunks;
         tail_q       <= start_tail;
      end else if (accept) begin
         beats_left_q <= beats_left_q - TOTAL_WIDTH'(1);
      end
   end

   always_comb begin
      logic signed [PW-1:0] a;
      logic signed [PW-1:0] b;
      a      = '0;
      b      = '0;
      prod_d = '0;
      for (int i = 0; i < NO_OF_UNITS; i++) begin
         a = PW'($signed(vector1[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
         b = PW'($signed(vector2[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
         if (last_beat && (tail_q != '0) && (LANE_W'(i) >= tail_q)) begin
            prod_d[i*PW +: PW] = '0;
         end else begin
            prod_d[i*PW +: PW] = a * b;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid1_q <= 1'b0;
         prod_q   <= '0;
      end else begin
         valid1_q <= accept;
         if (accept) prod_q <= prod_d;
      end
   end

   dot_lane_adder_tree #(
      .NO_OF_UNITS   (NO_OF_UNITS),
      .PRODUCT_WIDTH (PW),
      .ACC_WIDTH     (ACC_WIDTH)
   ) u_tree (
      .products (prod_q),
      .sum      (tree_sum)
   );

`ifdef DOT_PRODUCT_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

   logic signed [ACC_WIDTH:0] acc_wide;
   logic                      sat_hit;
   logic                      ovf_q;

   // One extra bit exposes signed overflow; its top bit is the true sign.
   always_comb begin
      acc_wide = {acc_q[ACC_WIDTH-1], acc_q} + {tree_sum[ACC_WIDTH-1], tree_sum};
      sat_hit  = (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]);
      if (!sat_hit)                acc_d = acc_wide[ACC_WIDTH-1:0];
      else if (acc_wide[ACC_WIDTH]) acc_d = ACC_MIN;
      else                         acc_d = ACC_MAX;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                       ovf_q <= 1'b0;
      else if (start_take)              ovf_q <= 1'b0;
      else if (valid1_q && sat_hit)     ovf_q <= 1'b1;
   end

   assign overflow = ovf_q;
`else
   always_comb acc_d = acc_q + tree_sum;

   assign overflow = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          acc_q <= '0;
      else if (start_take) acc_q <= '0;
      else if (valid1_q)   acc_q <= acc_d;
   end

endmodule

// File: tb/tb_dot_product_stream_ctrl.sv
// Directed self-checking bench for dot_product_stream_ctrl (default and minimum ACC_WIDTH).
module tb_dot_product_stream_ctrl;

   localparam int EW     = 32;
   localparam int N      = 8;
   localparam int AW     = 80;
   localparam int AW_MIN = 68;
   localparam int TW     = 32;

   logic            clk;
   logic            reset;
   logic            start;
   logic [TW-1:0]   total;
   logic            in_valid;
   logic            in_ready;
   logic [N*EW-1:0] vector1, vector2;
   logic [AW-1:0]   result;
   logic            finish;
   logic            result_ready;
   logic            busy;
   logic            overflow;

   logic              start_m;
   logic [TW-1:0]     total_m;
   logic              in_valid_m;
   logic              in_ready_m;
   logic [N*EW-1:0]   vector_m;
   logic [AW_MIN-1:0] result_m;
   logic              finish_m;
   logic              busy_m;
   logic              overflow_m;

   logic [N*EW-1:0] v1_mem [4];
   logic [N*EW-1:0] v2_mem [4];

   int n_checks = 0;
   int n_pass   = 0;

   dot_product_stream_ctrl #(
      .ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .ACC_WIDTH(AW), .TOTAL_WIDTH(TW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .total(total),
      .in_valid(in_valid), .in_ready(in_ready),
      .vector1(vector1), .vector2(vector2),
      .result(result), .finish(finish), .result_ready(result_ready),
      .busy(busy), .overflow(overflow)
   );

   dot_product_stream_ctrl #(
      .ELEMENT_WIDTH(EW), .NO_OF_UNITS(N), .ACC_WIDTH(AW_MIN), .TOTAL_WIDTH(TW)
   ) dut_min (
      .clk(clk), .reset(reset), .start(start_m), .total(total_m),
      .in_valid(in_valid_m), .in_ready(in_ready_m),
      .vector1(vector_m), .vector2(vector_m),
      .result(result_m), .finish(finish_m), .result_ready(1'b0),
      .busy(busy_m), .overflow(overflow_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [127:0] got,
                            input logic signed [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic logic [N*EW-1:0] splat(input logic [EW-1:0] x);
      return {N{x}};
   endfunction

   function automatic logic [N*EW-1:0] ramp();
      logic [N*EW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*EW +: EW] = EW'(i + 1);
      return v;
   endfunction

   // Streams v1_mem/v2_mem beats; in_valid follows vpat per cycle, then stays high.
   task automatic run_op(input string tag, input bit do_start, input logic [TW-1:0] t,
                         input int n_data, input logic [15:0] vpat,
                         input longint exp_res, input int exp_beats);
      int hs      = 0;
      int last_hs = -100;
      int fin_cyc = -1;
      int idx;
      if (do_start) begin
         @(negedge clk);
         in_valid = 1'b0;
         start    = 1'b1;
         total    = t;
         @(negedge clk);
         start = 1'b0;
      end
      total = '1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (finish) begin
            fin_cyc = cyc;
            break;
         end
         in_valid = (cyc < 16) ? vpat[cyc] : 1'b1;
         idx      = (hs < n_data) ? hs : n_data - 1;
         vector1  = v1_mem[idx];
         vector2  = v2_mem[idx];
         if (in_valid && in_ready) begin
            hs++;
            last_hs = cyc;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_val({tag, "_done"}, fin_cyc >= 0, 1);
      check_val({tag, "_result"}, $signed(result), exp_res);
      check_val({tag, "_beats"}, hs, exp_beats);
      check_val({tag, "_latency"}, fin_cyc - last_hs, 3);
      check_val({tag, "_in_ready"}, in_ready, 0);
      check_val({tag, "_overflow"}, overflow, 0);
   endtask

   task automatic release_result(input string tag);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check_val({tag, "_finish_clr"}, finish, 0);
      check_val({tag, "_busy_clr"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_m;
      int fin_m;
      reset = 1'b0; start = 1'b0; total = '0; in_valid = 1'b0;
      vector1 = '0; vector2 = '0; result_ready = 1'b0;
      start_m = 1'b0; total_m = '0; in_valid_m = 1'b0; vector_m = '0;
      #3;
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_finish", finish, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_overflow", overflow, 0);
      check_val("rst_result", $signed(result), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // 8 elements, one full beat: 1+2+...+8
      v1_mem[0] = ramp();     v2_mem[0] = splat(32'd1);
      run_op("full8", 1'b1, 32'd8, 1, 16'hFFFF, 36, 1);
      release_result("full8");

      // 13 elements: lanes 5-7 of beat 1 carry large values that must be masked
      v1_mem[0] = splat(32'd2); v2_mem[0] = splat(32'd3);
      v1_mem[1] = splat(32'd2); v2_mem[1] = splat(32'd3);
      for (int i = 5; i < N; i++) v1_mem[1][i*EW +: EW] = 32'h7FFF_FFFF;
      run_op("tail13", 1'b1, 32'd13, 2, 16'hFFFF, 78, 2);
      release_result("tail13");

      // 24 elements with in_valid gaps 1,0,0,1,0,1
      for (int k = 0; k < 3; k++) begin
         v1_mem[k] = splat(32'hFFFF_FFFF);
         v2_mem[k] = splat(32'd1);
      end
      run_op("gaps24", 1'b1, 32'd24, 3, 16'hFFE9, -24, 3);
      release_result("gaps24");

      // total of zero goes straight to DONE with a cleared result
      @(negedge clk);
      start = 1'b1; total = '0;
      @(negedge clk);
      start = 1'b0;
      check_val("zero_finish", finish, 1);
      check_val("zero_in_ready", in_ready, 0);
      check_val("zero_result", $signed(result), 0);
      release_result("zero");

      // reset mid-LOAD after one of three beats
      for (int k = 0; k < 3; k++) begin
         v1_mem[k] = splat(32'd5);
         v2_mem[k] = splat(32'd1);
      end
      @(negedge clk);
      start = 1'b1; total = 32'd24;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; vector1 = v1_mem[0]; vector2 = v2_mem[0];
      check_val("abort_in_ready_pre", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_val("abort_partial", $signed(result), 40);
      #2 reset = 1'b0;
      #1;
      check_val("abort_result", $signed(result), 0);
      check_val("abort_in_ready", in_ready, 0);
      check_val("abort_busy", busy, 0);
      check_val("abort_finish", finish, 0);
      @(negedge clk);
      reset = 1'b1;
      run_op("fresh8", 1'b1, 32'd8, 1, 16'hFFFF, 40, 1);
      release_result("fresh8");

      // hold finish with start pending, then back-to-back restart
      v1_mem[0] = ramp(); v2_mem[0] = splat(32'd1);
      v1_mem[1] = ramp(); v2_mem[1] = splat(32'd1);
      run_op("tail3", 1'b1, 32'd3, 1, 16'hFFFF, 6, 1);
      start = 1'b1; total = 32'd8;
      for (int k = 0; k < 5; k++) begin
         check_val("hold_finish", finish, 1);
         @(negedge clk);
      end
      check_val("hold_result", $signed(result), 6);
      result_ready = 1'b1; total = 32'd16;
      @(negedge clk);
      result_ready = 1'b0; start = 1'b0;
      check_val("b2b_in_ready", in_ready, 1);
      check_val("b2b_finish", finish, 0);
      check_val("b2b_result_clr", $signed(result), 0);
      run_op("b2b16", 1'b0, 32'd16, 2, 16'hFFFF, 72, 2);
      release_result("b2b16");

      // minimum-width accumulator: 8 beats of (2^31-1)^2 per lane exceed the signed range
      @(negedge clk);
      start_m = 1'b1; total_m = 32'd64;
      @(negedge clk);
      start_m = 1'b0; in_valid_m = 1'b1; vector_m = splat(32'h7FFF_FFFF);
      hs_m = 0; fin_m = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (finish_m) begin
            fin_m = 1;
            break;
         end
         if (in_valid_m && in_ready_m) hs_m++;
         @(negedge clk);
      end
      in_valid_m = 1'b0;
      check_val("min_done", fin_m, 1);
      check_val("min_beats", hs_m, 8);
`ifdef DOT_PRODUCT_SATURATE_EN
      check_val("min_result", $signed(result_m), 128'sh7FFFFFFFFFFFFFFFF);
      check_val("min_overflow", overflow_m, 1);
`else
      check_val("min_result", $signed(result_m), -64'sd274877906880);
      check_val("min_overflow", overflow_m, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
